bit_scan_encoder28: RTL and testbench
=====================================

Name: bit_scan_encoder28

Overview:
- Sequential encoder for 28-bit datapath words; the inverse direction of the 28-input OR-reduction used for zero detection.
- Instead of collapsing the word to a single "any bit set" flag, it scans the latched word one bit per clock.
- Reports the index of the lowest set bit plus a zero flag.
- Used by the ALU/normalisation path and the register-file decode checks wherever a one-hot 28-bit word must be turned back into a binary index.

Parameters:
- WIDTH, 28: operand width in bits.
- IDX_W, 5: index width; must satisfy 2**IDX_W >= WIDTH.

Ports:
- CLK      input   1       system clock, rising edge active
- RST      input   1       asynchronous active-low reset
- start    input   1       request to encode operand; sampled on rising CLK
- operand  input   WIDTH   word to encode; latched when start is accepted
- busy     output  1       high while a scan is in progress
- done     output  1       single-cycle pulse when results are valid
- index    output  IDX_W   position of the lowest set bit; 0 when zero=1
- zero     output  1       high when the latched operand had no set bit

Behaviour:
- Reset: RST low forces IDLE immediately (asynchronous).
  - busy=0, done=0, index=0, zero=0.
  - Internal latch and counter cleared.
  - A reset during a scan abandons it with no done pulse.
- State machine: IDLE, SCAN, DONE.
- IDLE:
  - If start=1 at a rising edge: latch operand into the shadow register, counter=0, go to SCAN, busy=1.
  - If start=0: remain in IDLE.
- SCAN:
  - Each rising edge examines shadow[counter].
  - If the bit is 1: index<=counter, zero<=0, go to DONE.
  - Else if counter==WIDTH-1: index<=0, zero<=1, go to DONE.
  - Else: counter<=counter+1.
  - Counter never exceeds WIDTH-1, so there is no wrap-around.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency: start accepted at edge 0; lowest set bit at position k makes done high in the cycle after edge k+1.
  - Operand 1: done in the cycle after edge 1.
  - Operand 0: done in the cycle after edge 28.
- Output hold: index and zero hold their values after done until the next accepted start, which clears neither until the new result is written.
- start while busy or in DONE: ignored, with no queueing.
- start in the same cycle as DONE→IDLE: ignored. A new start must be presented while in IDLE.
- Operand changes after acceptance have no effect; only the shadow register is scanned.
- Multiple set bits: only the lowest is reported.
- zero equals the inverse of the OR-reduction of the latched operand.

Optional Feature:
- Macro ONEHOT_CHECK_EN.
- When defined:
  - Adds an output port onehot_err (1 bit, reset 0).
  - SCAN always runs all WIDTH bits, giving a fixed latency with done in the cycle after edge 28.
  - index still reports the lowest set bit.
  - A second set bit sets onehot_err=1, valid with done and held until the next accepted start.
- When undefined:
  - No onehot_err port.
  - Early exit on the first set bit, with latency as above.

Test Plan:
- Reset mid-scan: operand=28'h8000000, start, then RST low after 5 edges → busy=0, done never pulses, index=0, zero=0.
- Zero operand: operand=0, start → done after 28 scan edges, zero=1, index=0.
- Walking one: operand=1<<k for k=0..27, one start each → index=k, zero=0, done in the cycle after edge k+1.
  - Example: 28'h0000100 → index=8.
- Multi-bit and ignored start: operand=28'h0000A00, start; during busy, assert start with operand=1 → index=9, zero=0.
  - The second start is ignored and yields no extra done.
- Output hold and back-to-back: after index=27 (operand=28'h8000000), hold start low for 10 cycles → index stays 27.
  - Then start with operand=28'h0000002 → index=1.
- ONEHOT_CHECK_EN builds:
  - operand=28'h0000006 → index=1, onehot_err=1, done after 28 edges.
  - operand=28'h0000004 → index=2, onehot_err=0.

Source files
------------

// File: rtl/bit_scan_encoder28.sv
// bit_scan_encoder28: sequential lowest-set-bit encoder for a 28-bit word.
// The operand is latched on an accepted start, then scanned one bit per clock
// from bit 0 upward. The scan reports the index of the lowest set bit, or
// zero=1 when no bit is set.
//
// Optional feature: define ONEHOT_CHECK_EN to add the onehot_err output. With
// the feature enabled, every scan runs all WIDTH bits, so latency is fixed, and
// a second set bit is flagged.
//
// Ports:
//   CLK        in   rising-edge clock
//   RST        in   asynchronous active-low reset
//   start      in   encode request, honoured only in IDLE
//   operand    in   [WIDTH-1:0] word to encode, latched on accepted start
//   busy       out  high while scanning
//   done       out  one-cycle pulse, results valid
//   index      out  [IDX_W-1:0] lowest set bit position (0 when zero=1)
//   zero       out  latched operand had no set bit
//   onehot_err out  more than one bit set (ONEHOT_CHECK_EN only)
module bit_scan_encoder28 #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned IDX_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] index,
`ifdef ONEHOT_CHECK_EN
    output logic             zero,
    output logic             onehot_err
`else
    output logic             zero
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [WIDTH-1:0]   shadow, shadow_d;
    logic [IDX_W-1:0]   counter, counter_d;
    logic               busy_d, done_d, zero_d;
    logic [IDX_W-1:0]   index_d;
    logic               cur_bit;
    logic               last_bit;

`ifdef ONEHOT_CHECK_EN
    // Full-scan bookkeeping: first set bit seen and whether a second one appeared.
    logic               found, found_d;
    logic [IDX_W-1:0]   first_idx, first_idx_d;
    logic               multi, multi_d;
    logic               onehot_err_d;
`endif

    assign cur_bit  = shadow[counter];
    assign last_bit = (counter == LAST_IDX);

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            shadow     <= '0;
            counter    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            index      <= '0;
            zero       <= 1'b0;
`ifdef ONEHOT_CHECK_EN
            found      <= 1'b0;
            first_idx  <= '0;
            multi      <= 1'b0;
            onehot_err <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            shadow     <= shadow_d;
            counter    <= counter_d;
            busy       <= busy_d;
            done       <= done_d;
            index      <= index_d;
            zero       <= zero_d;
`ifdef ONEHOT_CHECK_EN
            found      <= found_d;
            first_idx  <= first_idx_d;
            multi      <= multi_d;
            onehot_err <= onehot_err_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state;
        shadow_d  = shadow;
        counter_d = counter;
        busy_d    = busy;
        done_d    = 1'b0;
        index_d   = index;
        zero_d    = zero;
`ifdef ONEHOT_CHECK_EN
        found_d      = found;
        first_idx_d  = first_idx;
        multi_d      = multi;
        onehot_err_d = onehot_err;
`endif

        unique case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    shadow_d  = operand;
                    counter_d = '0;
                    busy_d    = 1'b1;
                    state_d   = SCAN;
`ifdef ONEHOT_CHECK_EN
                    found_d      = 1'b0;
                    first_idx_d  = '0;
                    multi_d      = 1'b0;
                    onehot_err_d = 1'b0;
`endif
                end
            end

            SCAN: begin
`ifdef ONEHOT_CHECK_EN
                // Scan every bit; the result is only written on the final bit.
                if (cur_bit) begin
                    if (found) begin
                        multi_d = 1'b1;
                    end else begin
                        found_d     = 1'b1;
                        first_idx_d = counter;
                    end
                end
                if (last_bit) begin
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    state_d      = DONE;
                    zero_d       = !(found || cur_bit);
                    onehot_err_d = multi || (found && cur_bit);
                    if (found) begin
                        index_d = first_idx;
                    end else if (cur_bit) begin
                        index_d = counter;
                    end else begin
                        index_d = '0;
                    end
                end else begin
                    counter_d = counter + IDX_W'(1);
                end
`else
                // Early exit on the first set bit.
                if (cur_bit) begin
                    index_d = counter;
                    zero_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (last_bit) begin
                    index_d = '0;
                    zero_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    counter_d = counter + IDX_W'(1);
                end
`endif
            end

            DONE: begin
                // start is deliberately ignored here; it must be presented in IDLE.
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_scan_encoder28.sv
// Directed self-checking bench for bit_scan_encoder28 with a scoreboard queue.
module tb_bit_scan_encoder28;

    logic        CLK;
    logic        RST;
    logic        start;
    logic [27:0] operand;
    logic        busy;
    logic        done;
    logic [4:0]  index;
    logic        zero;
    logic        err_obs;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] idx;
        logic       zero;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sb[$];

`ifdef ONEHOT_CHECK_EN
    logic onehot_err;
    assign err_obs = onehot_err;
    localparam bit FULL_SCAN = 1'b1;
`else
    assign err_obs = 1'b0;
    localparam bit FULL_SCAN = 1'b0;
`endif

    bit_scan_encoder28 dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .operand    (operand),
        .busy       (busy),
        .done       (done),
        .index      (index),
`ifdef ONEHOT_CHECK_EN
        .zero       (zero),
        .onehot_err (onehot_err)
`else
        .zero       (zero)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input int k);
        return FULL_SCAN ? 28 : k;
    endfunction

    // Issue one encode, optionally injecting an ignored start mid-scan at cycle inj_at.
    task automatic run(input logic [27:0] op, input logic [4:0] eidx, input logic ez,
                       input logic eerr, input int elat, input int inj_at, input string tag);
        exp_t e;
        int   n;
        bit   seen;
        start   = 1'b1;
        operand = op;
        sb.push_back('{idx: eidx, zero: ez, err: eerr, lat: elat});
        @(posedge CLK);
        #1;
        start   = 1'b0;
        operand = 28'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge CLK);
            n++;
            #1;
            if (inj_at >= 0 && n == inj_at) begin
                start   = 1'b1;
                operand = 28'd1;
            end
            if (n == inj_at + 2) start = 1'b0;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        e = sb.pop_front();
        check({tag, "_latency"}, 32'(n), 32'(e.lat));
        check({tag, "_index"}, 32'(index), 32'(e.idx));
        check({tag, "_zero"}, 32'(zero), 32'(e.zero));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        if (FULL_SCAN) check({tag, "_onehot_err"}, 32'(err_obs), 32'(e.err));
        @(posedge CLK);
        #1;
        check({tag, "_done_pulse_width"}, 32'(done), 32'd0);
    endtask

    initial begin
        bit saw_done;
        RST     = 1'b0;
        start   = 1'b0;
        operand = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_index", 32'(index), 32'd0);
        check("reset_zero", 32'(zero), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // Walking one: index k, done after edge k+1.
        for (int k = 0; k < 28; k++) begin
            logic [27:0] w;
            w = 28'd1 << k;
            run(w, 5'(k), 1'b0, 1'b0, exp_lat(k + 1), -1, $sformatf("walk%0d", k));
        end

        // Reset mid-scan: after index 27 result, abandon a new scan.
        start   = 1'b1;
        operand = 28'h8000000;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_index", 32'(index), 32'd0);
        check("rst_mid_zero", 32'(zero), 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(posedge CLK);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("rst_mid_no_done", 32'(saw_done), 32'd0);

        // Zero operand: full scan, zero flag.
        run(28'h0, 5'd0, 1'b1, 1'b0, 28, -1, "zero_op");

        // Multiple bits, with a start injected while busy.
        run(28'h0000A00, 5'd9, 1'b0, 1'b1, exp_lat(10), 2, "multi_ign");
        saw_done = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(posedge CLK);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("ignored_start_no_activity", 32'(saw_done), 32'd0);

        // Output hold and back-to-back.
        run(28'h8000000, 5'd27, 1'b0, 1'b0, exp_lat(28), -1, "top_bit");
        repeat (10) @(posedge CLK);
        #1;
        check("hold_index", 32'(index), 32'd27);
        check("hold_zero", 32'(zero), 32'd0);
        run(28'h0000002, 5'd1, 1'b0, 1'b0, exp_lat(2), -1, "after_hold");

        // Two-bit and single-bit words for the one-hot check.
        run(28'h0000006, 5'd1, 1'b0, 1'b1, exp_lat(2), -1, "two_bits");
        run(28'h0000004, 5'd2, 1'b0, 1'b0, exp_lat(3), -1, "one_bit");

        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
